// File: rtl/xtdot_force_seq.sv
// xtdot_force_seq: sequential spatial force transform f_out = X^T * f_in.
// One shared fixed-point MAC walks the 6x6 transform column by column.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_ready   input handshake for xform_in / f_in
//   xform_in [15*WIDTH]  packed link transform, low word first
//   f_in     [6*WIDTH]   input force AX,AY,AZ,LX,LY,LZ, low word first
//   out_valid, out_ready output handshake for f_out
//   f_out    [6*WIDTH]   transformed force, same packing as f_in
//
// Build option: XTDOT_SKIP_ZEROS_EN skips the structural-zero terms of X
// (23-term schedule instead of 36); results are bit-identical.
module xtdot_force_seq #(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15*WIDTH-1:0]  xform_in,
    input  logic [6*WIDTH-1:0]   f_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6*WIDTH-1:0]   f_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   xr [15];
    logic [WIDTH-1:0]   fr [6];
    logic [WIDTH-1:0]   acc;
    logic [2:0]         row;
    logic [2:0]         col;

    // Term (row,col) is X[col][row]; false only where X is structurally 0.
    function automatic logic live(input logic [2:0] r, input logic [2:0] c);
`ifdef XTDOT_SKIP_ZEROS_EN
        live = (r <= 3'd5) && (c <= 3'd5)
            && !(c == 3'd2 && r == 3'd0)
            && !(c == 3'd5 && (r == 3'd1 || r == 3'd2 || r == 3'd3))
            && !(c < 3'd3 && r >= 3'd3);
`else
        live = (r <= 3'd5) && (c <= 3'd5);
`endif
    endfunction

    // Coefficient X[col][row] from the 15 stored words.
    // X = [E 0; B E]; E[AZ][AX] and B[LZ][AY..AZ] are not stored.
    logic [2:0]       blk_a;
    logic [2:0]       blk_b;
    logic [3:0]       idx;
    logic             czero;
    logic [WIDTH-1:0] coef;

    always_comb begin
        blk_a = (col < 3'd3) ? col : col - 3'd3;
        blk_b = (row < 3'd3) ? row : row - 3'd3;
        idx   = '0;
        czero = 1'b0;
        if (col < 3'd3 && row >= 3'd3) begin
            czero = 1'b1;
        end else if (col >= 3'd3 && row < 3'd3) begin
            if (blk_a != 3'd2)
                idx = 4'd8 + 4'(blk_a) * 4'd3 + 4'(blk_b);
            else if (blk_b == 3'd0)
                idx = 4'd14;
            else
                czero = 1'b1;
        end else begin
            if (blk_a != 3'd2)
                idx = 4'(blk_a) * 4'd3 + 4'(blk_b);
            else if (blk_b != 3'd0)
                idx = 4'd5 + 4'(blk_b);
            else
                czero = 1'b1;
        end
        coef = czero ? '0 : xr[idx];
    end

    // Full-width signed product; bits [D +: W] equal (p >>> D) truncated.
    logic [WIDTH-1:0]          fcol;
    logic signed [2*WIDTH-1:0] pfull;
    logic [WIDTH-1:0]          prod;
    logic [WIDTH-1:0]          acc_sum;
    logic                      unused_pbits;

    always_comb begin
        fcol    = fr[col];
        pfull   = $signed({{WIDTH{coef[WIDTH-1]}}, coef})
                * $signed({{WIDTH{fcol[WIDTH-1]}}, fcol});
        prod    = pfull[DECIMAL_BITS +: WIDTH];
        acc_sum = acc + prod;
    end

    assign unused_pbits = ^{pfull[2*WIDTH-1:DECIMAL_BITS+WIDTH],
                            pfull[DECIMAL_BITS-1:0]};

    // Next live column in this row, and first live column of next row.
    logic [2:0] nxt_col;
    logic       more;
    logic [2:0] row_n;
    logic [2:0] first_col;

    always_comb begin
        nxt_col   = col;
        more      = 1'b0;
        row_n     = row + 3'd1;
        first_col = '0;
        for (int c = 5; c >= 0; c--) begin
            if (c > int'(col) && live(row, 3'(c))) begin
                nxt_col = 3'(c);
                more    = 1'b1;
            end
            if (live(row_n, 3'(c)))
                first_col = 3'(c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            f_out     <= '0;
            acc       <= '0;
            row       <= '0;
            col       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 15; i++)
                            xr[i] <= xform_in[i*WIDTH +: WIDTH];
                        for (int i = 0; i < 6; i++)
                            fr[i] <= f_in[i*WIDTH +: WIDTH];
                        acc      <= '0;
                        row      <= '0;
                        col      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (more) begin
                        acc <= acc_sum;
                        col <= nxt_col;
                    end else begin
                        f_out[32'(row)*WIDTH +: WIDTH] <= acc_sum;
                        acc <= '0;
                        if (row == 3'd5) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            row <= row_n;
                            col <= first_col;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xtdot_force_seq.sv
// tb_xtdot_force_seq: scoreboard bench for xtdot_force_seq.
// Directed plan cases plus random transforms against a matrix-level model.
module tb_xtdot_force_seq;

    localparam int W = 32;
`ifdef XTDOT_SKIP_ZEROS_EN
    localparam int LAT = 24;
`else
    localparam int LAT = 37;
`endif

    localparam int AX_AX = 0,  AX_AY = 1,  AX_AZ = 2;
    localparam int AY_AX = 3,  AY_AY = 4,  AY_AZ = 5;
    localparam int AZ_AY = 6,  AZ_AZ = 7;
    localparam int LX_AX = 8,  LX_AY = 9,  LX_AZ = 10;
    localparam int LY_AX = 11, LY_AY = 12, LY_AZ = 13;
    localparam int LZ_AX = 14;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15*W-1:0]   xform_in;
    logic [6*W-1:0]    f_in;
    logic              out_valid;
    logic              out_ready;
    logic [6*W-1:0]    f_out;

    xtdot_force_seq #(.WIDTH(W), .DECIMAL_BITS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xform_in  (xform_in),
        .f_in      (f_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6*W-1:0] f;
        int             hs;
    } exp_t;

    exp_t           sb[$];
    int             nvec = 0;
    int             nerr = 0;
    int             cyc = 0;
    bit             pend = 0;
    bit             chk_idle = 0;
    int             bp = 0;
    logic [6*W-1:0] held;

    task automatic chk(input string name, input logic [6*W-1:0] act,
                       input logic [6*W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fxmul(input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 32'(p >>> 16);
    endfunction

    // Builds X = [E 0; B E] and returns X^T * f with wrapping sums.
    function automatic logic [6*W-1:0] model(input logic [15*W-1:0] xf,
                                             input logic [6*W-1:0] f);
        logic [31:0] w [15];
        logic [31:0] e [3][3];
        logic [31:0] b [3][3];
        logic [31:0] x [6][6];
        logic [31:0] s;
        logic [6*W-1:0] r;
        for (int i = 0; i < 15; i++) w[i] = xf[i*W +: W];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                e[i][j] = 0;
                b[i][j] = 0;
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) begin
                e[i][j] = w[3*i+j];
                b[i][j] = w[8+3*i+j];
            end
        e[2][1] = w[AZ_AY];
        e[2][2] = w[AZ_AZ];
        b[2][0] = w[LZ_AX];
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                if (i < 3 && j < 3)       x[i][j] = e[i][j];
                else if (i < 3)           x[i][j] = 0;
                else if (j < 3)           x[i][j] = b[i-3][j];
                else                      x[i][j] = e[i-3][j-3];
        for (int rr = 0; rr < 6; rr++) begin
            s = 0;
            for (int c = 0; c < 6; c++)
                s = s + fxmul(x[c][rr], f[c*W +: W]);
            r[rr*W +: W] = s;
        end
        return r;
    endfunction

    function automatic logic [6*W-1:0] p6(input int a, input int b,
        input int c, input int d, input int e, input int f);
        return {32'(f), 32'(e), 32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [15*W-1:0] setw(input logic [15*W-1:0] x,
                                             input int i, input int v);
        x[i*W +: W] = 32'(v);
        return x;
    endfunction

    function automatic logic [31:0] rword();
        if ($urandom_range(0, 1) == 1) return $urandom;
        return 32'(int'($urandom_range(0, 1 << 19)) - (1 << 18));
    endfunction

    // Returns at the negedge right after the handshake edge.
    task automatic send(input logic [15*W-1:0] xf, input logic [6*W-1:0] f,
                        input logic [6*W-1:0] exp_f);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: in_ready stuck at %b", in_ready);
            return;
        end
        xform_in = xf;
        f_in     = f;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.push_back('{exp_f, cyc});
        chk("run_in_ready", 192'(in_ready), 192'(0));
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) xform_in[i*W +: W] = $urandom;
        for (int i = 0; i < 6; i++)  f_in[i*W +: W] = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || pend || chk_idle) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || pend) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_n && pend && out_valid && out_ready) begin
            pend     = 0;
            chk_idle = 1;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bp == 1)      out_ready = 1'b0;
            else if (bp == 2) out_ready = 1'b1;
            else              out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops on each new result, then watches it stay stable.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (chk_idle) begin
                    chk("idle_in_ready", 192'(in_ready), 192'(1));
                    chk("idle_out_valid", 192'(out_valid), 192'(0));
                    chk_idle = 0;
                end else if (pend) begin
                    if (!out_valid) begin
                        chk("valid_dropped", 192'(out_valid), 192'(1));
                        pend = 0;
                    end else begin
                        chk("hold_f_out", f_out, held);
                        chk("hold_in_ready", 192'(in_ready), 192'(0));
                    end
                end else if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 192'(out_valid), 192'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("f_out", f_out, e.f);
                        // valid is first presented at edge cyc+1
                        chk("latency", 192'(cyc - e.hs + 1), 192'(LAT));
                        held = e.f;
                        pend = 1;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15*W-1:0] xf;
        logic [6*W-1:0]  f;
        int              t;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        xform_in = '0;
        f_in     = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 192'(in_ready), 192'(1));
        chk("rst_out_valid", 192'(out_valid), 192'(0));
        chk("rst_f_out", f_out, '0);
        rst_n = 1'b1;

        // identity
        xf = '0;
        xf = setw(xf, AX_AX, 65536);
        xf = setw(xf, AY_AY, 65536);
        xf = setw(xf, AZ_AZ, 65536);
        f  = p6(65536, 2*65536, 3*65536, 4*65536, 5*65536, 6*65536);
        send(xf, f, f);

        // q=0 link
        xf = '0;
        xf = setw(xf, AX_AX, 65536);
        xf = setw(xf, AY_AY, 65536);
        xf = setw(xf, AZ_AZ, 65536);
        xf = setw(xf, LX_AY, 10322);
        xf = setw(xf, LY_AX, -10322);
        f  = p6(65536, 65536, 65536, 65536, 65536, 65536);
        send(xf, f, p6(55214, 75858, 65536, 65536, 65536, 65536));

        // q=90deg
        xf = '0;
        xf = setw(xf, AX_AY, 65536);
        xf = setw(xf, AY_AX, -65536);
        xf = setw(xf, AZ_AZ, 65536);
        xf = setw(xf, LX_AX, -10322);
        xf = setw(xf, LY_AY, -10322);
        f  = p6(0, 0, 0, 65536, 0, 0);
        send(xf, f, p6(-10322, 0, 0, 0, 65536, 0));

        // floor rounding of a negative product
        xf = '0;
        xf = setw(xf, AX_AX, 1);
        f  = p6(-1, 0, 0, 0, 0, 0);
        send(xf, f, p6(-1, 0, 0, 0, 0, 0));
        drain();

        // backpressure: hold out_ready low for 10 cycles of valid
        bp = 1;
        xf = '0;
        for (int i = 0; i < 15; i++) xf[i*W +: W] = rword();
        for (int i = 0; i < 6; i++)  f[i*W +: W] = rword();
        send(xf, f, model(xf, f));
        t = 0;
        while (!pend && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_seen", 192'(pend), 192'(1));
        repeat (10) @(negedge clk);
        bp = 2;
        drain();
        bp = 0;

        // reset in the middle of a run
        xf = '0;
        for (int i = 0; i < 15; i++) xf[i*W +: W] = 32'h0001_0000 + 32'(i);
        f = p6(65536, 2*65536, 3*65536, 4*65536, 5*65536, 6*65536);
        send(xf, f, model(xf, f));
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 192'(in_ready), 192'(1));
        chk("midrst_out_valid", 192'(out_valid), 192'(0));
        chk("midrst_f_out", f_out, '0);
        void'(sb.pop_back());
        rst_n = 1'b1;
        send(xf, f, model(xf, f));
        drain();

        // random transforms and forces
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 15; i++) xf[i*W +: W] = rword();
            for (int i = 0; i < 6; i++)  f[i*W +: W] = rword();
            send(xf, f, model(xf, f));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/xtdot_force_seq.md
Name: xtdot_force_seq

Overview:
- Sequential spatial force transform for the backward (force) pass: f_out = X^T * f_in.
- Consumes the 15-entry link transform produced by the per-link xgen blocks, plus a 6-element spatial force.
- Reuses one fixed-point multiply-accumulate over many cycles, trading latency for area.
- Sits between the xgen outputs and the backward-pass force accumulators; valid/ready on both sides.

Parameters:
WIDTH, 32, fixed-point word width (two's complement)
DECIMAL_BITS, 16, fractional bits; 1.0 = 2^DECIMAL_BITS

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  xform_in and f_in valid
in_ready  out  1  block can accept an input
xform_in  in  15*WIDTH  packed transform entries, low word first: AX_AX,AX_AY,AX_AZ,AY_AX,AY_AY,AY_AZ,AZ_AY,AZ_AZ,LX_AX,LX_AY,LX_AZ,LY_AX,LY_AY,LY_AZ,LZ_AX
f_in  in  6*WIDTH  input force, low word first: AX,AY,AZ,LX,LY,LZ
out_valid  out  1  f_out valid
out_ready  in  1  downstream accepts f_out
f_out  out  6*WIDTH  transformed force, same packing as f_in

Behaviour:
- Reset: only rst_n low at a clock edge resets the block; FSM goes to IDLE. Outputs after reset: in_ready=1, out_valid=0, f_out=0.
- Reset mid-operation discards the in-flight result with the same values.
- Matrix X (6x6, rows/cols AX,AY,AZ,LX,LY,LZ) = [E 0; B E].
- E is the 3x3 block from the AX..AZ rows, with E[AZ][AX]=0.
- B is the 3x3 block from the LX..LZ rows, with B[LZ][AY]=B[LZ][AZ]=0.
- Structural zeros: X[AZ][AX], X[LZ][AY], X[LZ][AZ], X[LZ][LX], and the whole top-right block.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch xform_in and f_in into internal registers, clear acc, row=0, col=0, go to RUN. Inputs may change after the handshake.
  - RUN: in_ready=0. Each cycle acc += prod(X[col][row], f[col]). col increments 0..5.
    - At col==5, write (acc+prod) to f_out word[row], clear acc, col=0, row++.
    - After row 5 completes, go to DONE.
  - DONE: out_valid=1 and f_out is stable. On out_ready, go to IDLE with out_valid=0.
- f_out keeps its last value in IDLE and RUN; individual words update during RUN.
- Latency: handshake at cycle 0, 36 MAC cycles, out_valid rises at cycle 37. Throughput is one result per 38 cycles minimum.
- Arithmetic:
  - prod = low WIDTH bits of ((a*b) computed at 2*WIDTH, then >>> DECIMAL_BITS). This is arithmetic shift, i.e. floor.
  - acc is WIDTH bits and wraps modulo 2^WIDTH; no saturation.
- Simultaneous events: in_valid during RUN/DONE is ignored (in_ready=0). out_ready outside DONE has no effect.

Optional Feature:
- Macro: XTDOT_SKIP_ZEROS_EN.
- With the macro defined: the schedule skips the structural zeros listed above, giving a fixed ordered list of 23 (row,col) terms.
  - Rows AX..AZ: 8 E terms and 7 B terms. Rows LX..LZ: 8 E terms.
  - out_valid rises at cycle 24.
- Without the macro: the full dense 36-term schedule runs.
- Results are bit-identical either way.

Test Plan:
- Identity: AX_AX=AY_AY=AZ_AZ=65536, rest 0; f_in=(1,2,3,4,5,6)*65536 -> f_out=f_in; out_valid at cycle 37 (24 with macro).
- q=0 link: cos=65536, sin=0, LX_AY=10322, LY_AX=-10322, AZ_AZ=65536; f_in all 65536 -> f_out=(55214,75858,65536,65536,65536,65536).
- q=90deg: AX_AY=65536, AY_AX=-65536, AZ_AZ=65536, LX_AX=-10322, LY_AY=-10322; f_in=(0,0,0,65536,0,0) -> f_out=(-10322,0,0,0,65536,0).
- Floor rounding: AX_AX=1 raw, rest 0; f_in AX=-1 raw, rest 0 -> f_out AX=-1 (not 0), others 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and f_out stay stable, in_ready=0; out_ready=1 -> next cycle IDLE, in_ready=1.
- Reset mid-run: drop rst_n at cycle 15 of RUN -> next cycle in_ready=1, out_valid=0, f_out=0; a new input then completes correctly.
